// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner with hex decode, blanking, blink,
// leading-zero suppression, PWM dimming and frame-synchronous updates.
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       wr_en,
  input  logic [NUM_DIGITS-1:0][3:0] digits,
  input  logic [NUM_DIGITS-1:0]      dp_mask,
  input  logic [NUM_DIGITS-1:0]      blank_mask,
  input  logic [NUM_DIGITS-1:0]      blink_mask,
  input  logic                       lz_en,
  input  logic [PWM_BITS-1:0]        brightness,
  input  logic                       disp_en,
  output logic [7:0]                 seg,
  output logic [NUM_DIGITS-1:0]      an,
  output logic                       frame_done,
  output logic                       upd_pending
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] dig;
    logic [NUM_DIGITS-1:0]      dp;
    logic [NUM_DIGITS-1:0]      blank;
    logic [NUM_DIGITS-1:0]      blink;
    logic                       lz;
    logic [PWM_BITS-1:0]        bright;
  } cfg_t;

  cfg_t              w_in;
  cfg_t              r_shadow;
  cfg_t              r_act;
  logic [DW-1:0]     r_div;
  logic [IW-1:0]     r_idx;
  logic [PWM_BITS-1:0] r_pwm;
  logic [BW-1:0]     r_blink_cnt;
  logic              r_phase;

  logic                  w_slot_end;
  logic                  w_wrap;
  logic                  w_lit;
  logic                  w_dark;
  logic                  w_zero_above;
  logic [NUM_DIGITS-1:0] w_lz;

  function automatic logic [6:0] f_glyph(input logic [3:0] v);
    f_glyph = 7'h00;
    unique case (v)
      4'h0: f_glyph = 7'h3F;
      4'h1: f_glyph = 7'h06;
      4'h2: f_glyph = 7'h5B;
      4'h3: f_glyph = 7'h4F;
      4'h4: f_glyph = 7'h66;
      4'h5: f_glyph = 7'h6D;
      4'h6: f_glyph = 7'h7D;
      4'h7: f_glyph = 7'h07;
      4'h8: f_glyph = 7'h7F;
      4'h9: f_glyph = 7'h6F;
      4'hA: f_glyph = 7'h77;
      4'hB: f_glyph = 7'h7C;
      4'hC: f_glyph = 7'h39;
      4'hD: f_glyph = 7'h5E;
      4'hE: f_glyph = 7'h79;
      4'hF: f_glyph = 7'h71;
    endcase
  endfunction

  assign w_in = '{
    dig:    digits,
    dp:     dp_mask,
    blank:  blank_mask,
    blink:  blink_mask,
    lz:     lz_en,
    bright: brightness
  };

  assign w_slot_end = (r_div == DW'(SCAN_DIV - 1));
  assign w_wrap = w_slot_end && (r_idx == IW'(NUM_DIGITS - 1));
  assign w_lit = disp_en && (r_pwm <= r_act.bright);

  // A digit is a leading zero only while every digit above it is a bare zero
  always_comb begin
    w_zero_above = 1'b1;
    w_lz = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_above = w_zero_above
                   && (r_act.dig[k] == 4'h0)
                   && !r_act.dp[k];
      w_lz[k] = r_act.lz && w_zero_above && (k != 0);
    end
  end

  assign w_dark = r_act.blank[r_idx]
                | (r_act.blink[r_idx] & r_phase)
                | w_lz[r_idx];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_div       <= '0;
      r_idx       <= '0;
      r_pwm       <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_pwm <= r_pwm + PWM_BITS'(1);
      if (w_slot_end) begin
        r_div <= '0;
        if (r_idx == IW'(NUM_DIGITS - 1)) r_idx <= '0;
        else                              r_idx <= r_idx + IW'(1);
      end else begin
        r_div <= r_div + DW'(1);
      end
      if (w_wrap) begin
        if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end
    end
  end

  // Commit uses the old shadow even if a new write lands on the wrap cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_shadow    <= '0;
      r_act       <= '0;
      upd_pending <= 1'b0;
    end else begin
      if (w_wrap && upd_pending) r_act <= r_shadow;
      if (wr_en) begin
        r_shadow    <= w_in;
        upd_pending <= 1'b1;
      end else if (w_wrap) begin
        upd_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      seg        <= '0;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_wrap;
      if (!w_lit) begin
        seg <= '0;
        an  <= '0;
      end else begin
        an <= AN_ONE << r_idx;
        if (w_dark) seg <= '0;
        else seg <= {r_act.dp[r_idx], f_glyph(r_act.dig[r_idx])};
      end
    end
  end

endmodule
